// File: rtl/cpu_defs.sv
// Shared front-end definitions: the fetched-instruction record and the
// fetch/issue widths used by the instruction queue and its neighbours.
package cpu_defs;

   localparam int FETCH_NUM = 2;
   localparam int ISSUE_NUM = 2;

   typedef struct packed {
      logic        valid;
      logic [31:0] vaddr;
      logic [31:0] instr;
      logic        exc_valid;
      logic [3:0]  exc_cause;
   } fetch_entry_t;

endpackage

// File: rtl/instr_queue_chk.sv
// Property checker for instr_queue: legal push sizes and bounded occupancy.
module instr_queue_chk #(
   parameter int DEPTH     = 16,
   parameter int FETCH_NUM = 2
) (
   input logic                           clk,
   input logic                           rst_n,
   input logic [$clog2(FETCH_NUM+1)-1:0] push_num,
   input logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PNW = $clog2(FETCH_NUM+1);
   localparam int CW  = $clog2(DEPTH+1);

   a_push_num_legal: assert property (@(posedge clk) disable iff (!rst_n)
      push_num <= PNW'(FETCH_NUM));

   a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
      count <= CW'(DEPTH));

endmodule

// File: rtl/instr_queue.sv
// Circular instruction buffer between fetch and dual issue: multi-entry push
// at the tail, first-word-fall-through presentation and clipped pop at the head.
module instr_queue
   import cpu_defs::*;
#(
   parameter int DEPTH     = 16,
   parameter int FETCH_NUM = cpu_defs::FETCH_NUM,
   parameter int ISSUE_NUM = cpu_defs::ISSUE_NUM
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  flush,
   input  logic [$clog2(FETCH_NUM+1)-1:0]        push_num,
   input  fetch_entry_t [FETCH_NUM-1:0]          push_entry,
   output logic                                  push_ready,
   input  logic [$clog2(ISSUE_NUM+1)-1:0]        pop_num,
   output fetch_entry_t [ISSUE_NUM-1:0]          fetch_entry,
   output logic [$clog2(DEPTH+1)-1:0]            count,
   output logic                                  empty
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int PNW = $clog2(FETCH_NUM+1);

   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [CW-1:0] count_r;
   fetch_entry_t  mem_r [DEPTH];

   logic          push_en_s;
   logic [CW-1:0] push_cnt_s;
   logic [CW-1:0] pop_cnt_s;

   // Readiness looks only at the registered count; a same-cycle pop never frees room.
   assign push_ready = ((CW'(DEPTH) - count_r) >= CW'(FETCH_NUM));
   assign count      = count_r;
   assign empty      = (count_r == {CW{1'b0}});

   // Accepted push size and pop size clipped to the current occupancy.
   always_comb begin
      push_en_s  = 1'b0;
      push_cnt_s = {CW{1'b0}};
      pop_cnt_s  = {CW{1'b0}};
      if (!flush && push_ready && (push_num != {PNW{1'b0}})) begin
         push_en_s  = 1'b1;
         push_cnt_s = CW'(push_num);
      end else begin
         push_en_s  = 1'b0;
         push_cnt_s = {CW{1'b0}};
      end
      if (CW'(pop_num) > count_r) begin
         pop_cnt_s = count_r;
      end else begin
         pop_cnt_s = CW'(pop_num);
      end
   end

   // Pointer and occupancy state; flush wins over any same-cycle push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (flush) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         head_r  <= head_r + PW'(pop_cnt_s);
         tail_r  <= tail_r + PW'(push_cnt_s);
         count_r <= count_r + push_cnt_s - pop_cnt_s;
      end
   end

   // Storage writes: contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_NUM; i++) begin
         if (push_en_s && (PNW'(i) < push_num)) begin
            mem_r[tail_r + PW'(i)] <= push_entry[i];
         end
      end
   end

   // Oldest entries with stored valid bits replaced by occupancy.
   always_comb begin
      for (int i = 0; i < ISSUE_NUM; i++) begin
         fetch_entry[i]       = mem_r[head_r + PW'(i)];
         fetch_entry[i].valid = (CW'(i) < count_r);
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// Randomised scoreboard bench for instr_queue against a queue-based reference model.
module tb_instr_queue;
   import cpu_defs::*;

   localparam int DEPTH = 16;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic                        flush = 1'b0;
   logic [1:0]                  push_num = 2'd0;
   logic [1:0]                  pop_num = 2'd0;
   fetch_entry_t [1:0]          push_entry = '0;
   fetch_entry_t [1:0]          fetch_entry;
   logic                        push_ready;
   logic                        empty;
   logic [4:0]                  count;

   typedef struct {
      int           cnt;
      bit           emp;
      bit           rdy;
      fetch_entry_t ent [2];
   } exp_t;

   exp_t         exp_q [$];
   fetch_entry_t model_q [$];
   int           checks = 0;
   int           errors = 0;
   int           instr_seq = 32'h100;

   always #5 clk = ~clk;

   instr_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .push_num    (push_num),
      .push_entry  (push_entry),
      .push_ready  (push_ready),
      .pop_num     (pop_num),
      .fetch_entry (fetch_entry),
      .count       (count),
      .empty       (empty)
   );

   instr_queue_chk #(.DEPTH(DEPTH), .FETCH_NUM(FETCH_NUM)) chk_u (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_num (push_num),
      .count    (count)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      e.cnt = model_q.size();
      e.emp = (model_q.size() == 0);
      e.rdy = ((DEPTH - model_q.size()) >= FETCH_NUM);
      for (int i = 0; i < 2; i++) begin
         if (i < model_q.size()) begin
            e.ent[i]       = model_q[i];
            e.ent[i].valid = 1'b1;
         end else begin
            e.ent[i] = '0;
         end
      end
      return e;
   endfunction

   // Monitor: one expectation per clock edge, compared just after the edge.
   initial begin
      forever begin : mon
         exp_t e;
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", count, e.cnt);
            chk("empty", empty, e.emp);
            chk("push_ready", push_ready, e.rdy);
            for (int i = 0; i < 2; i++) begin
               chk($sformatf("valid%0d", i), fetch_entry[i].valid, e.ent[i].valid);
               if (e.ent[i].valid) begin
                  chk($sformatf("entry%0d", i), fetch_entry[i], e.ent[i]);
               end
            end
         end
      end
   end

   task automatic step(input bit fl, input int pn, input int pp);
      int sz;
      int np;
      bit rdy;
      @(negedge clk);
      flush    = fl;
      push_num = pn[1:0];
      pop_num  = pp[1:0];
      for (int i = 0; i < 2; i++) begin
         push_entry[i] = {1'($urandom), 32'($urandom), 32'(instr_seq + i), 1'($urandom), 4'($urandom)};
      end
      instr_seq += 2;
      if (fl) begin
         model_q.delete();
      end else begin
         sz  = model_q.size();
         rdy = ((DEPTH - sz) >= FETCH_NUM);
         np  = (pp < sz) ? pp : sz;
         repeat (np) void'(model_q.pop_front());
         if (rdy) begin
            for (int i = 0; i < pn; i++) model_q.push_back(push_entry[i]);
         end
      end
      exp_q.push_back(snapshot());
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      flush    = 1'b0;
      push_num = 2'd0;
      pop_num  = 2'd0;
      model_q.delete();
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_empty", empty, 1);
      chk("async_rst_valid0", fetch_entry[0].valid, 0);
      exp_q.push_back(snapshot());
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(snapshot());
   endtask

   initial begin
      do_reset();
      step(1'b0, 0, 0);
      // fill to full, then one dropped push
      repeat (9) step(1'b0, 2, 0);
      // drain through count 3 -> 2 -> 1 -> 0 with an over-pop at the end
      repeat (6) step(1'b0, 0, 2);
      step(1'b0, 0, 1);
      step(1'b0, 0, 1);
      step(1'b0, 0, 1);
      step(1'b0, 0, 2);
      // simultaneous push and pop at count 14
      repeat (7) step(1'b0, 2, 0);
      step(1'b0, 2, 2);
      repeat (7) step(1'b0, 0, 2);
      // park pointers at DEPTH-1, then push across the wrap
      repeat (7) step(1'b0, 2, 0);
      step(1'b0, 1, 0);
      repeat (7) step(1'b0, 0, 2);
      step(1'b0, 0, 1);
      step(1'b0, 2, 0);
      step(1'b0, 0, 0);
      step(1'b0, 0, 2);
      // flush with competing push and pop at count 6
      repeat (3) step(1'b0, 2, 0);
      step(1'b1, 2, 1);
      step(1'b0, 0, 0);
      // asynchronous reset mid-stream
      repeat (4) step(1'b0, 2, 0);
      do_reset();
      step(1'b0, 0, 0);
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 31) == 0), $urandom_range(0, 2), $urandom_range(0, 2));
      end
      @(negedge clk);
      flush    = 1'b0;
      push_num = 2'd0;
      pop_num  = 2'd0;
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
